// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution stage.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    // Full-precision result: wide enough for the signed 32x32 product.
    typedef logic signed [63:0] result_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } exec_state_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational evaluator for one instruction word; operands are sign-extended
// to the result width first, so -2^31 / -1 yields +2^31 without overflow.
module instr_alu
    import instr_register_pkg::*;
(
    input  instruction_t iw_i,
    output result_t      res_o,
    output logic         err_o
);

    result_t a_ext;
    result_t b_ext;
    logic    b_zero;

    assign a_ext  = {{32{iw_i.op_a[31]}}, iw_i.op_a};
    assign b_ext  = {{32{iw_i.op_b[31]}}, iw_i.op_b};
    assign b_zero = (iw_i.op_b == '0);

    // Opcode evaluation; division by zero yields 0 and flags the error bit.
    always_comb begin
        res_o = '0;
        err_o = 1'b0;
        case (iw_i.opc)
            ZERO:  res_o = '0;
            PASSA: res_o = a_ext;
            PASSB: res_o = b_ext;
            ADD:   res_o = a_ext + b_ext;
            SUB:   res_o = a_ext - b_ext;
            MULT:  res_o = a_ext * b_ext;
            DIV: begin
                if (b_zero) err_o = 1'b1;
                else        res_o = a_ext / b_ext;
            end
            MOD: begin
                if (b_zero) err_o = 1'b1;
                else        res_o = a_ext % b_ext;
            end
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_exec_unit.sv
// Execution stage: walks the instruction register read pointer, evaluates each
// word and presents one result per instruction on a valid/ready port.
module instr_exec_unit
    import instr_register_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned RES_W = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  address_t                first_addr,
    input  logic [5:0]              count,
    output address_t                read_pointer,
    input  instruction_t            instruction_word,
    output logic                    busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [RES_W-1:0] res_data,
    output opcode_t                 res_opc,
    output address_t                res_addr,
    output logic                    res_err,
    output logic                    done
);

    exec_state_t             state_q, state_d;
    address_t                rp_q, rp_d;
    logic [5:0]              rem_q, rem_d;
    instruction_t            iw_q, iw_d;
    address_t                addr_q, addr_d;
    logic signed [RES_W-1:0] res_data_q, res_data_d;
    opcode_t                 res_opc_q, res_opc_d;
    address_t                res_addr_q, res_addr_d;
    logic                    res_err_q, res_err_d;
    logic                    valid_q, valid_d;

    result_t                 alu_res;
    logic                    alu_err;
    logic [5:0]              count_clamped;

    assign count_clamped = (count > 6'(DEPTH)) ? 6'(DEPTH) : count;

    instr_alu u_alu (
        .iw_i  (iw_q),
        .res_o (alu_res),
        .err_o (alu_err)
    );

    // Next-state logic for the run FSM, pointer and result registers.
    always_comb begin
        state_d    = state_q;
        rp_d       = rp_q;
        rem_d      = rem_q;
        iw_d       = iw_q;
        addr_d     = addr_q;
        res_data_d = res_data_q;
        res_opc_d  = res_opc_q;
        res_addr_d = res_addr_q;
        res_err_d  = res_err_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rp_d    = first_addr;
                    rem_d   = count_clamped;
                    state_d = (count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                iw_d    = instruction_word;
                addr_d  = rp_q;
                state_d = EXEC;
            end
            EXEC: begin
                res_data_d = RES_W'(alu_res);
                res_opc_d  = iw_q.opc;
                res_addr_d = addr_q;
                res_err_d  = alu_err;
                valid_d    = 1'b1;
                rem_d      = rem_q - 6'd1;
                state_d    = OUT;
            end
            OUT: begin
                if (valid_q && res_ready) begin
                    valid_d = 1'b0;
                    if (rem_q != '0) begin
                        rp_d    = rp_q + address_t'(1);
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any run and discards a pending result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rp_q       <= '0;
            rem_q      <= '0;
            iw_q       <= '0;
            addr_q     <= '0;
            res_data_q <= '0;
            res_opc_q  <= ZERO;
            res_addr_q <= '0;
            res_err_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rp_q       <= rp_d;
            rem_q      <= rem_d;
            iw_q       <= iw_d;
            addr_q     <= addr_d;
            res_data_q <= res_data_d;
            res_opc_q  <= res_opc_d;
            res_addr_q <= res_addr_d;
            res_err_q  <= res_err_d;
            valid_q    <= valid_d;
        end
    end

    assign read_pointer = rp_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign res_valid    = valid_q;
    assign res_data     = res_data_q;
    assign res_opc      = res_opc_q;
    assign res_addr     = res_addr_q;
    assign res_err      = res_err_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: table vectors, hand-written corner sequences and
// random runs checked against an arithmetic reference model.
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    address_t     first_addr;
    logic [5:0]   count;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         busy;
    logic         res_valid;
    logic         res_ready;
    logic signed [63:0] res_data;
    opcode_t      res_opc;
    address_t     res_addr;
    logic         res_err;
    logic         done;

    instruction_t mem [32];
    assign instruction_word = mem[read_pointer];

    int errors = 0;
    int checks = 0;

    longint   log_data[$];
    bit       log_err[$];
    address_t log_addr[$];

    instr_exec_unit #(.DEPTH(32), .RES_W(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .first_addr       (first_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .busy             (busy),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_opc          (res_opc),
        .res_addr         (res_addr),
        .res_err          (res_err),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference semantics: sign-magnitude division, remainder from the quotient.
    function automatic void ref_exec(input instruction_t iw, output longint r, output bit e);
        longint a, b, ma, mb, q;
        a = longint'(signed'(iw.op_a));
        b = longint'(signed'(iw.op_b));
        r = 0;
        e = 1'b0;
        case (iw.opc)
            ZERO:  r = 0;
            PASSA: r = a;
            PASSB: r = b;
            ADD:   r = a + b;
            SUB:   r = a - b;
            MULT:  r = a * b;
            DIV, MOD: begin
                if (b == 0) begin
                    e = 1'b1;
                end else begin
                    ma = (a < 0) ? -a : a;
                    mb = (b < 0) ? -b : b;
                    q  = ma / mb;
                    if ((a < 0) != (b < 0)) q = -q;
                    r = (iw.opc == DIV) ? q : a - q * b;
                end
            end
            default: r = 0;
        endcase
    endfunction

    function automatic operand_t rnd_operand();
        case ($urandom_range(0, 5))
            0:       return operand_t'(0);
            1:       return operand_t'(32'h8000_0000);
            2:       return operand_t'(-1);
            3:       return operand_t'(32'h7fff_ffff);
            4:       return operand_t'($urandom_range(0, 20)) - operand_t'(10);
            default: return operand_t'($urandom);
        endcase
    endfunction

    // Starts one run and consumes every result, checking against the model.
    task automatic do_run(input address_t fa, input int cnt, input bit rnd_ready,
                          input string tag);
        int n, k, done_cyc, first_valid_cyc;
        bit stall;
        longint sv_data, er;
        bit sv_err, ee;
        address_t sv_addr, sv_rp, ea;
        n = (cnt > 32) ? 32 : cnt;
        k = 0;
        done_cyc = -1;
        first_valid_cyc = -1;
        stall = 1'b0;
        log_data.delete(); log_err.delete(); log_addr.delete();
        @(negedge clk);
        first_addr = fa; count = 6'(cnt); start = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy after start"}, 64'(busy), 1);
        for (int cyc = 0; cyc < 600 && done_cyc < 0; cyc++) begin
            if (done) begin
                done_cyc = cyc;
            end else begin
                res_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (stall) begin
                    check({tag, " held valid"}, 64'(res_valid), 1);
                    check({tag, " held data"}, res_data, sv_data);
                    check({tag, " held addr"}, 64'(res_addr), 64'(sv_addr));
                    check({tag, " held err"}, 64'(res_err), 64'(sv_err));
                    check({tag, " held rp"}, 64'(read_pointer), 64'(sv_rp));
                end
                if (res_valid) begin
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    if (res_ready) begin
                        stall = 1'b0;
                        ea = address_t'(fa + address_t'(k));
                        ref_exec(mem[ea], er, ee);
                        check({tag, " data"}, res_data, er);
                        check({tag, " err"}, 64'(res_err), 64'(ee));
                        check({tag, " addr"}, 64'(res_addr), 64'(ea));
                        check({tag, " opc"}, 64'(res_opc), 64'(mem[ea].opc));
                        log_data.push_back(res_data);
                        log_err.push_back(res_err);
                        log_addr.push_back(res_addr);
                        k++;
                    end else begin
                        stall   = 1'b1;
                        sv_data = res_data;
                        sv_addr = res_addr;
                        sv_err  = res_err;
                        sv_rp   = read_pointer;
                    end
                end
                @(negedge clk);
            end
        end
        res_ready = 1'b0;
        check({tag, " done reached"}, 64'(done_cyc >= 0), 1);
        check({tag, " result count"}, 64'(k), 64'(n));
        check({tag, " first valid cycle"}, 64'(first_valid_cyc), (n > 0) ? 64'sd2 : -64'sd1);
        if (!rnd_ready) check({tag, " done cycle"}, 64'(done_cyc), 64'(3 * n));
        @(negedge clk);
        check({tag, " done one cycle"}, 64'(done), 0);
        check({tag, " idle after done"}, 64'(busy), 0);
    endtask

    typedef struct {
        opcode_t opc;
        int      a;
        int      b;
        longint  exp_res;
        bit      exp_err;
    } vec_t;

    vec_t vecs [15];

    initial begin
        longint sv_d;
        int wait_n;
        bit done_seen;
        address_t wrap_exp [4];

        vecs = '{
            '{ADD,   5,            7,            64'sd12,                   1'b0},
            '{SUB,   3,            10,           -64'sd7,                   1'b0},
            '{MULT,  -4,           6,            -64'sd24,                  1'b0},
            '{PASSA, -9,           100,          -64'sd9,                   1'b0},
            '{DIV,   7,            0,            64'sd0,                    1'b1},
            '{MOD,   -7,           2,            -64'sd1,                   1'b0},
            '{DIV,   32'h80000000, -1,           64'sd2147483648,           1'b0},
            '{DIV,   -7,           2,            -64'sd3,                   1'b0},
            '{MOD,   7,            -2,           64'sd1,                    1'b0},
            '{MULT,  32'h7fffffff, 32'h80000000, -64'sd4611686016279904256, 1'b0},
            '{PASSB, 1,            -5,           -64'sd5,                   1'b0},
            '{ZERO,  3,            4,            64'sd0,                    1'b0},
            '{MOD,   5,            0,            64'sd0,                    1'b1},
            '{SUB,   32'h80000000, 32'h7fffffff, -64'sd4294967295,          1'b0},
            '{ADD,   32'h7fffffff, 32'h7fffffff, 64'sd4294967294,           1'b0}
        };
        for (int i = 0; i < 32; i++) mem[i] = '0;

        reset = 1'b1; start = 1'b0; first_addr = '0; count = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 0);
        check("reset valid", 64'(res_valid), 0);
        check("reset data", res_data, 0);
        check("reset opc", 64'(res_opc), 64'(ZERO));
        check("reset addr", 64'(res_addr), 0);
        check("reset err", 64'(res_err), 0);
        check("reset done", 64'(done), 0);
        check("reset rp", 64'(read_pointer), 0);
        reset = 1'b0;

        // Table vectors at addresses 0..14, consumed back to back.
        for (int i = 0; i < 15; i++) begin
            mem[i].opc  = vecs[i].opc;
            mem[i].op_a = operand_t'(vecs[i].a);
            mem[i].op_b = operand_t'(vecs[i].b);
        end
        do_run(5'd0, 15, 1'b0, "table");
        for (int i = 0; i < 15; i++) begin
            if (i < log_data.size()) begin
                check($sformatf("vec%0d res", i), log_data[i], vecs[i].exp_res);
                check($sformatf("vec%0d err", i), 64'(log_err[i]), 64'(vecs[i].exp_err));
            end else begin
                check($sformatf("vec%0d missing", i), 0, 1);
            end
        end
        do_run(5'd0, 3, 1'b0, "first three");

        // Pointer wrap from 30.
        wrap_exp = '{5'd30, 5'd31, 5'd0, 5'd1};
        do_run(5'd30, 4, 1'b0, "wrap");
        for (int i = 0; i < 4; i++) begin
            if (i < log_addr.size()) check($sformatf("wrap addr%0d", i), 64'(log_addr[i]), 64'(wrap_exp[i]));
            else check($sformatf("wrap addr%0d missing", i), 0, 1);
        end

        do_run(5'd7, 0, 1'b0, "count zero");

        // Stalled first result; start pulses must be ignored.
        mem[10] = '{opc: ADD,  op_a: 32'sd1, op_b: 32'sd2};
        mem[11] = '{opc: SUB,  op_a: 32'sd9, op_b: 32'sd4};
        mem[20] = '{opc: MULT, op_a: 32'sd3, op_b: 32'sd3};
        @(negedge clk);
        first_addr = 5'd10; count = 6'd2; start = 1'b1; res_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_n = 0;
        while (!res_valid && wait_n < 10) begin @(negedge clk); wait_n++; end
        check("stall valid", 64'(res_valid), 1);
        sv_d = res_data;
        check("stall first data", res_data, 3);
        for (int s = 0; s < 5; s++) begin
            start = (s == 2);
            first_addr = 5'd20; count = 6'd1;
            @(negedge clk);
            check("stall data", res_data, sv_d);
            check("stall addr", 64'(res_addr), 10);
            check("stall rp", 64'(read_pointer), 10);
            check("stall valid held", 64'(res_valid), 1);
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check("stall rp advance", 64'(read_pointer), 11);
        wait_n = 0;
        while (!res_valid && wait_n < 10) begin @(negedge clk); wait_n++; end
        check("stall second data", res_data, 5);
        check("stall second addr", 64'(res_addr), 11);
        @(negedge clk);
        check("stall done", 64'(done), 1);
        res_ready = 1'b0;
        @(negedge clk);
        check("stall idle", 64'(busy), 0);

        // Reset while the second result is waiting.
        for (int i = 0; i < 32; i++) begin
            mem[i].opc = opcode_t'($urandom_range(0, 7));
            mem[i].op_a = rnd_operand();
            mem[i].op_b = rnd_operand();
        end
        first_addr = 5'd3; count = 6'd8; start = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_n = 0;
        while (!res_valid && wait_n < 10) begin @(negedge clk); wait_n++; end
        @(negedge clk);
        res_ready = 1'b0;
        wait_n = 0;
        while (!res_valid && wait_n < 10) begin @(negedge clk); wait_n++; end
        check("abort in second OUT", 64'(res_valid), 1);
        check("abort addr before reset", 64'(res_addr), 4);
        reset = 1'b1;
        #1;
        check("abort busy", 64'(busy), 0);
        check("abort valid", 64'(res_valid), 0);
        check("abort data", res_data, 0);
        check("abort opc", 64'(res_opc), 64'(ZERO));
        check("abort addr", 64'(res_addr), 0);
        check("abort err", 64'(res_err), 0);
        check("abort rp", 64'(read_pointer), 0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done || res_valid || busy) done_seen = 1'b1;
            @(negedge clk);
        end
        check("abort quiet", 64'(done_seen), 0);
        do_run(5'd3, 8, 1'b0, "after abort");

        // Random runs including clamped counts and random back-pressure.
        do_run(5'($urandom_range(0, 31)), 40, 1'b1, "clamp");
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 32; i++) begin
                mem[i].opc = opcode_t'($urandom_range(0, 7));
                mem[i].op_a = rnd_operand();
                mem[i].op_b = rnd_operand();
            end
            do_run(5'($urandom_range(0, 31)), $urandom_range(0, 36), 1'(r % 4 != 0),
                   $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_exec_unit.md
# instr_exec_unit

Downstream execution stage for the instruction register. Given a start address and count, it walks the register's read pointer, captures each `instruction_t` word, evaluates the opcode on its two signed operands, and presents one 64-bit result per instruction on a valid/ready output port. It is the consumer of everything the test bench loads into `instr_register`.

## Interface
- `DEPTH`, default 32: instruction register depth; must equal 2**$bits(address_t).
- `RES_W`, default 64: result width; holds the full signed 32x32 product.

- `clk`  in  1  single clock; all state is updated on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request a run; sampled only in IDLE.
- `first_addr`  in  address_t  first instruction address of the run.
- `count`  in  6  number of instructions, 0..32.
- `read_pointer`  out  address_t  drives the `instr_register` read address.
- `instruction_word`  in  instruction_t  combinational read data from `instr_register`.
- `busy`  out  1  high in every state except IDLE.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  signed RES_W  result value.
- `res_opc`  out  opcode_t  opcode that produced `res_data`.
- `res_addr`  out  address_t  address the instruction was read from.
- `res_err`  out  1  DIV or MOD with `op_b == 0`.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- FSM states are IDLE, FETCH, EXEC, OUT and DONE.
- **IDLE:** on `start`:
  - load `read_pointer <= first_addr` and `remaining <= count`.
  - If `count == 0`, go to DONE. Otherwise go to FETCH.
- **FETCH:** `read_pointer` is stable. On the edge, capture `instruction_word` and `read_pointer` into `iw_q` and `addr_q`, then go to EXEC.
- **EXEC:** evaluate `iw_q` and register `res_data`, `res_opc`, `res_addr` and `res_err`. Set `res_valid <= 1`, decrement `remaining`, then go to OUT.
- **OUT:** hold all `res_*` outputs stable while `res_valid && !res_ready`. On an edge with `res_valid && res_ready`:
  - clear `res_valid`.
  - If `remaining != 0`, set `read_pointer <= read_pointer + 1` (31 wraps to 0) and go to FETCH.
  - Otherwise go to DONE.
- **DONE:** `done = 1` for exactly one cycle, then go to IDLE.
- `start` is ignored in every state except IDLE.
- `count > 32` is clamped to 32.
- Arithmetic: operands are sign-extended to RES_W before the operation.
  - ZERO gives 0.
  - PASSA gives a. PASSB gives b.
  - ADD gives a+b. SUB gives a-b. Neither can overflow at 64 bits.
  - MULT gives the full signed product.
  - DIV truncates toward zero. MOD takes the sign of the dividend.
  - DIV or MOD with b == 0 gives result 0 and `res_err = 1`. `res_err = 0` for all other cases.
  - -2^31 / -1 = +2^31, with no error.

## Timing
- Reset values: state IDLE; `read_pointer` 0; `busy`, `res_valid`, `res_data`, `res_err`, `done` and `res_addr` all 0; `res_opc` ZERO.
- Reset asserted mid-run aborts immediately:
  - no `done` pulse.
  - any pending result is discarded.
- Latency: start accepted at edge E0, `iw_q` captured at E1, `res_valid` rises after E2.
- With `res_ready` held high, throughput is one result every 3 cycles.
- `done` is asserted the cycle after the last handshake edge.
- `busy` rises the cycle after start is accepted and falls when the FSM returns to IDLE.
- `count == 0`: the `done` pulse starts one cycle after the start edge; no `res_valid` is ever asserted.
- `res_ready` may be high before `res_valid`; no combinational path from `res_ready` to any output.

## Structure
- Add the following to `instr_register_pkg`:
  - `result_t` (signed [63:0]).
  - `exec_state_t` enum.
- Reuse the existing package types `opcode_t`, `operand_t`, `address_t` and `instruction_t`.
- One combinational sub-module, `instr_alu`:
  - inputs: `instruction_t`.
  - outputs: `result_t` and the error bit.
- The FSM, pointer and output registers live in `instr_exec_unit`.

## Test plan
- Load addr 0: ADD 5,7; addr 1: SUB 3,10; addr 2: MULT -4,6. Run start addr 0, count 3 with `res_ready = 1`.
  - Expect 12, -7, -24, `res_addr` 0, 1, 2, and `done` after the third result.
- Load addr 4: DIV 7,0; addr 5: MOD -7,2.
  - Expect result 0 with `res_err = 1`, then -1 with `res_err = 0`.
- Run start addr 30, count 4.
  - Expect `res_addr` 30, 31, 0, 1 (pointer wrap).
- Hold `res_ready = 0` for 5 cycles on the first result.
  - `res_*` stays constant and `read_pointer` stays frozen.
  - Pulsing `start` during this time has no effect.
- Start with `count = 0`: expect `done` only, no `res_valid`.
- Start with `count = 8` and assert `reset` while in the second OUT state.
  - All outputs return to their reset values and no `done` pulse occurs.
  - A subsequent start runs normally.
